// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and helpers for the pipeline hazard controller and its
//   destination tracker.
//   - fwd_sel_t    : operand-forwarding select encoding driven to ID
//   - hz_state_t   : controller FSM states
//   - trk_ctrl_t   : per-stage control for the destination tracker
//   - dest_entry_t : one tracked destination {w, we, load}
//   - entry_valid / entry_hit : register-0-aware match helpers
package hazard_pkg;

  // Register indices are carried at this fixed width inside the tracker so the
  // struct can live in the package. Narrower REG_W values are zero-extended on
  // entry, which preserves equality comparisons.
  localparam int HZ_REG_W_MAX = 8;

  typedef logic [HZ_REG_W_MAX-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_DM = 2'b10
  } fwd_sel_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    TRK_LOAD   = 2'b00,
    TRK_BUBBLE = 2'b01,
    TRK_HOLD   = 2'b10
  } trk_ctrl_t;

  typedef struct packed {
    reg_idx_t w;
    logic     we;
    logic     load;
  } dest_entry_t;

  localparam dest_entry_t DEST_BUBBLE = '0;

  // An entry only counts as a pending write when it really writes and the
  // target is not the hardwired zero register.
  function automatic logic entry_valid(input dest_entry_t e);
    return e.we && (e.w != '0);
  endfunction

  // True when a source that is actually read matches a pending write.
  function automatic logic entry_hit(input dest_entry_t e,
                                     input logic        use_src,
                                     input reg_idx_t    req);
    return use_src && entry_valid(e) && (req == e.w);
  endfunction

endpackage

// File: rtl/hazard_dest_tracker.sv
// hazard_dest_tracker
//   Holds the destination entries of the instructions currently in EX and DM.
//   Each stage can load, take a bubble, or hold, under control of the hazard
//   controller FSM. DM always loads from the current EX entry.
//   Ports:
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     i_ex_ctrl      : EX entry control (load i_ex_next / bubble / hold)
//     i_dm_ctrl      : DM entry control (load EX entry / bubble / hold)
//     i_ex_next      : entry describing the ID instruction advancing into EX
//     o_ex, o_dm     : current EX and DM entries
module hazard_dest_tracker
  import hazard_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  trk_ctrl_t   i_ex_ctrl,
  input  trk_ctrl_t   i_dm_ctrl,
  input  dest_entry_t i_ex_next,
  output dest_entry_t o_ex,
  output dest_entry_t o_dm
);

  dest_entry_t r_ex;
  dest_entry_t r_dm;

  // EX entry: takes the ID instruction, a bubble, or keeps the instruction
  // that is still occupying EX (multi-cycle mult/div).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex <= DEST_BUBBLE;
    end else begin
      case (i_ex_ctrl)
        TRK_LOAD:   r_ex <= i_ex_next;
        TRK_BUBBLE: r_ex <= DEST_BUBBLE;
        default:    r_ex <= r_ex;
      endcase
    end
  end

  // DM entry: advances from the pre-edge EX entry, or is bubbled while EX is
  // held so the held instruction is not counted twice.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dm <= DEST_BUBBLE;
    end else begin
      case (i_dm_ctrl)
        TRK_LOAD:   r_dm <= r_ex;
        TRK_BUBBLE: r_dm <= DEST_BUBBLE;
        default:    r_dm <= r_dm;
      endcase
    end
  end

  assign o_ex = r_ex;
  assign o_dm = r_dm;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Central hazard controller for the 5-stage pipeline. Owns every stall and
//   flush decision: load-use stalls, taken-branch flushes and multi-cycle
//   mult/div occupancy of EX. Also drives the ID operand-forwarding selects.
//   Parameters:
//     MD_LATENCY : cycles a mult/div occupies EX (>= 1)
//     REG_W      : register index width (<= HZ_REG_W_MAX)
//   Ports:
//     i_clk, i_rst_n              : clock, asynchronous active-low reset
//     i_id_req_a/b, i_id_use_a/b  : ID source indices and read qualifiers
//     i_id_req_w, i_id_we         : ID destination index and write enable
//     i_id_is_load, i_id_is_md    : ID instruction class
//     i_ex_branch_taken           : branch resolved taken in EX
//     o_pc_en, o_ifid_en, o_idex_en : pipeline-register enables
//     o_ifid_flush, o_idex_bubble, o_exdm_bubble : bubble/flush controls
//     o_fwd_a, o_fwd_b            : 00 regfile, 01 EX result, 10 DM result
//     o_md_busy                   : controller is waiting on mult/div
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int REG_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [REG_W-1:0] i_id_req_a,
  input  logic [REG_W-1:0] i_id_req_b,
  input  logic             i_id_use_a,
  input  logic             i_id_use_b,
  input  logic [REG_W-1:0] i_id_req_w,
  input  logic             i_id_we,
  input  logic             i_id_is_load,
  input  logic             i_id_is_md,
  input  logic             i_ex_branch_taken,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_exdm_bubble,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_md_busy
);

  // The counter holds the remaining MD_WAIT cycles minus one, so its largest
  // value is MD_LATENCY-2; keep at least one bit for the MD_LATENCY=1 build.
  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0);

  hz_state_t        r_state;
  hz_state_t        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;

  dest_entry_t w_ex;
  dest_entry_t w_dm;
  dest_entry_t w_ex_next;
  trk_ctrl_t   w_ex_ctrl;
  trk_ctrl_t   w_dm_ctrl;

  reg_idx_t    w_req_a;
  reg_idx_t    w_req_b;
  fwd_sel_t    w_fwd_a;
  fwd_sel_t    w_fwd_b;
  logic        w_load_use;

  logic        w_pc_en;
  logic        w_ifid_en;
  logic        w_idex_en;
  logic        w_ifid_flush;
  logic        w_idex_bubble;
  logic        w_exdm_bubble;
  logic        w_md_busy;

  assign w_req_a   = reg_idx_t'(i_id_req_a);
  assign w_req_b   = reg_idx_t'(i_id_req_b);
  assign w_ex_next = '{w: reg_idx_t'(i_id_req_w), we: i_id_we, load: i_id_is_load};

  hazard_dest_tracker u_tracker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ex_ctrl (w_ex_ctrl),
    .i_dm_ctrl (w_dm_ctrl),
    .i_ex_next (w_ex_next),
    .o_ex      (w_ex),
    .o_dm      (w_dm)
  );

  // Operand forwarding is purely combinational and active in every state.
  // EX is checked first because it holds the younger producer.
  always_comb begin
    w_fwd_a = FWD_RF;
    if (entry_hit(w_ex, i_id_use_a, w_req_a)) begin
      w_fwd_a = FWD_EX;
    end else if (entry_hit(w_dm, i_id_use_a, w_req_a)) begin
      w_fwd_a = FWD_DM;
    end

    w_fwd_b = FWD_RF;
    if (entry_hit(w_ex, i_id_use_b, w_req_b)) begin
      w_fwd_b = FWD_EX;
    end else if (entry_hit(w_dm, i_id_use_b, w_req_b)) begin
      w_fwd_b = FWD_DM;
    end
  end

  // A load in EX cannot forward its result yet, so any real read of its
  // destination from ID must wait one cycle.
  assign w_load_use = w_ex.load &&
                      (entry_hit(w_ex, i_id_use_a, w_req_a) ||
                       entry_hit(w_ex, i_id_use_b, w_req_b));

  // Stall/flush sequencing. In RUN a taken branch beats a load-use stall,
  // which beats normal issue; a mult/div entering EX only starts the wait
  // when it was not squashed by a flush. In MD_WAIT the front of the pipe is
  // frozen, EX holds the mult/div and DM receives bubbles; branches cannot
  // resolve here because EX is occupied, so the branch input is ignored.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exdm_bubble = 1'b0;
    w_md_busy     = 1'b0;
    w_ex_ctrl     = TRK_LOAD;
    w_dm_ctrl     = TRK_LOAD;

    case (r_state)
      RUN: begin
        if (i_ex_branch_taken) begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_ex_ctrl     = TRK_BUBBLE;
        end else if (w_load_use) begin
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_bubble = 1'b1;
          w_ex_ctrl     = TRK_BUBBLE;
        end else if (i_id_is_md && (MD_LATENCY > 1)) begin
          w_next_state = MD_WAIT;
          w_next_cnt   = CNT_INIT;
        end
      end
      MD_WAIT: begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exdm_bubble = 1'b1;
        w_md_busy     = 1'b1;
        w_ex_ctrl     = TRK_HOLD;
        w_dm_ctrl     = TRK_BUBBLE;
        if (r_cnt == '0) begin
          w_next_state = RUN;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  // FSM state and wait counter; reset aborts any wait in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  assign o_pc_en       = w_pc_en;
  assign o_ifid_en     = w_ifid_en;
  assign o_idex_en     = w_idex_en;
  assign o_ifid_flush  = w_ifid_flush;
  assign o_idex_bubble = w_idex_bubble;
  assign o_exdm_bubble = w_exdm_bubble;
  assign o_fwd_a       = w_fwd_a;
  assign o_fwd_b       = w_fwd_b;
  assign o_md_busy     = w_md_busy;

endmodule
